src_rate_controller: RTL and testbench
======================================

Name: src_rate_controller

Overview:
- Run-time programmable rate source for the sample-rate-converter (SRC) interpolator/decimator pair in the acquisition path.
- Accepts requested interpolation/decimation rates from the control/timebase logic over a valid/ready handshake and range-checks them.
- Applies a new rate with a drain/settle sequence: rate valids drop, the datapath flushes, rates update, then valids reassert.
- Generates a fixed startup holdoff after reset before the first valid.

Parameters:
- RATE_W, 3, width of all rate buses.
- DEFAULT_RATE, 1, int_rate/dec_rate value after reset; must lie in 1..MAX_RATE.
- MAX_RATE, 7, largest legal rate; must be at most 2^RATE_W-1.
- STARTUP_CYCLES, 63, cycles after reset release before the first valid assertion; must be at least 1.
- FLUSH_CYCLES, 16, drain cycles between valid deassertion and the rate update; must be at least 1.
- SETTLE_CYCLES, 8, cycles between the rate update and valid reassertion; must be at least 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- req_int_rate  in  RATE_W  requested interpolation rate.
- req_dec_rate  in  RATE_W  requested decimation rate.
- req_valid  in  1  request present; held until accepted.
- req_ready  out  1  high only in RUN.
- int_rate  out  RATE_W  current interpolation rate (registered).
- int_valid  out  1  int_rate usable by the datapath.
- dec_rate  out  RATE_W  current decimation rate (registered).
- dec_valid  out  1  dec_rate usable by the datapath.
- busy  out  1  high in any state other than RUN.
- done  out  1  one-cycle pulse when a rate change completes or a no-op request is accepted.
- err  out  1  one-cycle pulse when an illegal request is rejected.

Behaviour:
- Reset values:
  - int_rate = dec_rate = DEFAULT_RATE.
  - int_valid = dec_valid = 0; done = err = 0.
  - state STARTUP, counter 0; busy = 1, req_ready = 0.
- All outputs are registered. int_valid and dec_valid are always equal. Acceptance means req_valid & req_ready at a rising edge.
- STARTUP:
  - Counter increments each cycle with rst low.
  - At the edge where counter == STARTUP_CYCLES-1: valids go 1, state goes to RUN.
  - The first valid is seen STARTUP_CYCLES cycles after the first low-rst edge.
- RUN:
  - req_ready = 1. On acceptance, check both rates.
  - Illegal: a rate of 0 or a rate > MAX_RATE. Pulse err next cycle; rates and valids unchanged; stay in RUN.
  - Legal and equal to the current rates: pulse done next cycle; valids stay high; stay in RUN.
  - Legal and different: latch the pending rates; valids go 0 at the accepting edge E0; state goes to DRAIN, counter 0.
- DRAIN:
  - Counts FLUSH_CYCLES edges.
  - At edge E0+FLUSH_CYCLES: int_rate/dec_rate take the pending values; state goes to SETTLE, counter 0.
- SETTLE:
  - Counts SETTLE_CYCLES edges.
  - At edge E0+FLUSH_CYCLES+SETTLE_CYCLES: valids go 1, done pulses for one cycle, state goes to RUN.
- Timing summary:
  - Valids are low for exactly FLUSH_CYCLES+SETTLE_CYCLES cycles.
  - Rates change while valids are low, never while they are high.
- Requests outside RUN: req_ready = 0, so the request is not accepted. A held req_valid is accepted on the first RUN cycle, which can be the same cycle valids reassert.
- Changing only one rate still runs the full drain/settle sequence for both channels.
- Reset at any point, including mid-DRAIN or mid-SETTLE:
  - Pending rates are discarded.
  - Outputs return to the reset values.
  - STARTUP restarts from 0.
- Counter width is at least clog2(max(STARTUP_CYCLES, FLUSH_CYCLES, SETTLE_CYCLES)+1). The counter never wraps.
- done and err never assert in the same cycle.

Test Plan:
- Reset held 5 cycles, then released -> valids 0 for 63 cycles, 1 from cycle 63; rates 1/1; busy falls with valid.
- In RUN, request int=4, dec=2 -> valids 0 from E0+1; rates become 4/2 at E0+16; valids 1 and done pulse at E0+24; busy high E0+1..E0+24.
- Request int=0, dec=3, then int=1, dec=7 with MAX_RATE=6 -> err pulse each time; rates/valids unchanged; no busy.
- Request equal to the current rates -> done pulse next cycle; valids never drop.
- Keep req_valid high with new values during DRAIN -> req_ready 0, no acceptance; second change starts on the first RUN cycle.
- Assert rst at E0+10 mid-DRAIN -> rates 1/1, valids 0, startup count restarts; pending rates never appear.

Source files
------------

// File: rtl/src_rate_controller.sv
// ----------------------------------------------------------------------------
// src_rate_controller
//
// Run-time programmable rate source for the SRC interpolator/decimator pair.
// It accepts requested interpolation/decimation rates over a valid/ready
// handshake and range-checks them. A legal new rate is applied with a
// drain/settle sequence: the rate valids drop, the datapath is given
// FLUSH_CYCLES to empty, the rates update, and after SETTLE_CYCLES more the
// valids reassert. After reset a fixed STARTUP_CYCLES holdoff runs before
// the first valid.
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous, active-high reset
//   req_int_rate  in   requested interpolation rate
//   req_dec_rate  in   requested decimation rate
//   req_valid     in   request present, held until accepted
//   req_ready     out  high only while in RUN
//   int_rate      out  current interpolation rate (registered)
//   int_valid     out  int_rate usable by the datapath
//   dec_rate      out  current decimation rate (registered)
//   dec_valid     out  dec_rate usable by the datapath (always == int_valid)
//   busy          out  high in any state other than RUN
//   done          out  one-cycle pulse: rate change finished / no-op accepted
//   err           out  one-cycle pulse: illegal request rejected
// ----------------------------------------------------------------------------
module src_rate_controller #(
    parameter int RATE_W         = 3,
    parameter int DEFAULT_RATE   = 1,
    parameter int MAX_RATE       = 7,
    parameter int STARTUP_CYCLES = 63,
    parameter int FLUSH_CYCLES   = 16,
    parameter int SETTLE_CYCLES  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RATE_W-1:0] req_int_rate,
    input  logic [RATE_W-1:0] req_dec_rate,
    input  logic              req_valid,
    output logic              req_ready,
    output logic [RATE_W-1:0] int_rate,
    output logic              int_valid,
    output logic [RATE_W-1:0] dec_rate,
    output logic              dec_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // One shared counter serves all three timed phases, so it is sized for
    // the longest of them and never has to wrap.
    localparam int MAX_CNT_A = (STARTUP_CYCLES > FLUSH_CYCLES) ? STARTUP_CYCLES : FLUSH_CYCLES;
    localparam int MAX_CNT   = (MAX_CNT_A > SETTLE_CYCLES) ? MAX_CNT_A : SETTLE_CYCLES;
    localparam int CNT_W     = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0]  STARTUP_LAST = CNT_W'(STARTUP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  FLUSH_LAST   = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [RATE_W-1:0] MAX_RATE_V   = RATE_W'(MAX_RATE);
    localparam logic [RATE_W-1:0] DEFAULT_V    = RATE_W'(DEFAULT_RATE);

    typedef enum logic [1:0] {
        ST_STARTUP,
        ST_RUN,
        ST_DRAIN,
        ST_SETTLE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RATE_W-1:0] int_rate_q, int_rate_d;
    logic [RATE_W-1:0] dec_rate_q, dec_rate_d;
    logic [RATE_W-1:0] pend_int_q, pend_int_d;
    logic [RATE_W-1:0] pend_dec_q, pend_dec_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic accept;
    logic req_legal;
    logic req_same;

    // A rate of zero is meaningless for either filter, and anything above
    // MAX_RATE is outside what the datapath was built for.
    assign req_legal = (req_int_rate != '0) && (req_int_rate <= MAX_RATE_V) &&
                       (req_dec_rate != '0) && (req_dec_rate <= MAX_RATE_V);
    assign req_same  = (req_int_rate == int_rate_q) && (req_dec_rate == dec_rate_q);

    // ready_q is only ever high in RUN, so this is the handshake as seen by
    // the requester.
    assign accept = req_valid & ready_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        int_rate_d = int_rate_q;
        dec_rate_d = dec_rate_q;
        pend_int_d = pend_int_q;
        pend_dec_d = pend_dec_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_STARTUP: begin
                if (cnt_q == STARTUP_LAST) begin
                    valid_d = 1'b1;
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RUN: begin
                if (accept) begin
                    if (!req_legal) begin
                        err_d = 1'b1;
                    end else if (req_same) begin
                        done_d = 1'b1;
                    end else begin
                        // Both channels go through the full sequence even
                        // if only one rate actually changes.
                        pend_int_d = req_int_rate;
                        pend_dec_d = req_dec_rate;
                        valid_d    = 1'b0;
                        state_d    = ST_DRAIN;
                        cnt_d      = '0;
                    end
                end
            end

            ST_DRAIN: begin
                if (cnt_q == FLUSH_LAST) begin
                    int_rate_d = pend_int_q;
                    dec_rate_d = pend_dec_q;
                    state_d    = ST_SETTLE;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_STARTUP;
                cnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase

        // Status outputs are registered from the next state so they line up
        // with the state register itself.
        busy_d  = (state_d != ST_RUN);
        ready_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_STARTUP;
            cnt_q      <= '0;
            int_rate_q <= DEFAULT_V;
            dec_rate_q <= DEFAULT_V;
            pend_int_q <= DEFAULT_V;
            pend_dec_q <= DEFAULT_V;
            valid_q    <= 1'b0;
            busy_q     <= 1'b1;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            int_rate_q <= int_rate_d;
            dec_rate_q <= dec_rate_d;
            pend_int_q <= pend_int_d;
            pend_dec_q <= pend_dec_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign req_ready = ready_q;
    assign int_rate  = int_rate_q;
    assign dec_rate  = dec_rate_q;
    assign int_valid = valid_q;
    assign dec_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_src_rate_controller.sv
// ----------------------------------------------------------------------------
// tb_src_rate_controller
//
// Directed bench for src_rate_controller built with MAX_RATE = 6 so that a
// rate of 7 is out of range. Inputs are driven and outputs sampled on the
// falling clock edge; each edge count below refers to rising edges.
// ----------------------------------------------------------------------------
module tb_src_rate_controller;

    localparam int RATE_W = 3;

    logic              clk;
    logic              rst;
    logic [RATE_W-1:0] req_int_rate;
    logic [RATE_W-1:0] req_dec_rate;
    logic              req_valid;
    logic              req_ready;
    logic [RATE_W-1:0] int_rate;
    logic              int_valid;
    logic [RATE_W-1:0] dec_rate;
    logic              dec_valid;
    logic              busy;
    logic              done;
    logic              err;

    int testCount;
    int failCount;

    src_rate_controller #(
        .RATE_W(RATE_W),
        .DEFAULT_RATE(1),
        .MAX_RATE(6),
        .STARTUP_CYCLES(63),
        .FLUSH_CYCLES(16),
        .SETTLE_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_int_rate(req_int_rate),
        .req_dec_rate(req_dec_rate),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .int_rate(int_rate),
        .int_valid(int_valid),
        .dec_rate(dec_rate),
        .dec_valid(dec_valid),
        .busy(busy),
        .done(done),
        .err(err)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, landing on the following falling edge.
    task automatic waitEdges(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a request onto the handshake inputs.
    task automatic applyStimulus(input logic v, input logic [RATE_W-1:0] ir,
                                 input logic [RATE_W-1:0] dr);
        req_valid    = v;
        req_int_rate = ir;
        req_dec_rate = dr;
    endtask

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Snapshot of every status output against expected values.
    task automatic checkAll(input string tag, input int ir, input int dr,
                            input logic v, input logic b, input logic rd,
                            input logic dn, input logic er);
        checkOutput({tag, ".int_rate"}, 8'(int_rate), 8'(ir));
        checkOutput({tag, ".dec_rate"}, 8'(dec_rate), 8'(dr));
        checkOutput({tag, ".int_valid"}, 8'(int_valid), 8'(v));
        checkOutput({tag, ".dec_valid"}, 8'(dec_valid), 8'(v));
        checkOutput({tag, ".busy"}, 8'(busy), 8'(b));
        checkOutput({tag, ".req_ready"}, 8'(req_ready), 8'(rd));
        checkOutput({tag, ".done"}, 8'(done), 8'(dn));
        checkOutput({tag, ".err"}, 8'(err), 8'(er));
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 3'd0, 3'd0);

        // Reset held for 5 edges
        waitEdges(5);
        checkAll("reset", 1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Startup holdoff: valid appears after the 63rd low-reset edge
        rst = 1'b0;
        waitEdges(62);
        checkAll("startup62", 1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        waitEdges(1);
        checkAll("startup63", 1, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Rate change to 4/2, accepted at edge E0
        applyStimulus(1'b1, 3'd4, 3'd2);
        waitEdges(1);
        applyStimulus(1'b0, 3'd0, 3'd0);
        checkAll("chg.e0", 1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        waitEdges(15);
        checkAll("chg.e15", 1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        waitEdges(1);
        checkAll("chg.e16", 4, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        waitEdges(7);
        checkAll("chg.e23", 4, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        waitEdges(1);
        checkAll("chg.e24", 4, 2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        waitEdges(1);
        checkAll("chg.e25", 4, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Illegal: zero interpolation rate
        applyStimulus(1'b1, 3'd0, 3'd3);
        waitEdges(1);
        applyStimulus(1'b0, 3'd0, 3'd0);
        checkAll("ill0", 4, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        waitEdges(1);
        checkAll("ill0.after", 4, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Illegal: decimation rate above MAX_RATE (6)
        applyStimulus(1'b1, 3'd1, 3'd7);
        waitEdges(1);
        applyStimulus(1'b0, 3'd0, 3'd0);
        checkAll("ill7", 4, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        waitEdges(1);
        checkAll("ill7.after", 4, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // No-op request equal to current rates
        applyStimulus(1'b1, 3'd4, 3'd2);
        waitEdges(1);
        applyStimulus(1'b0, 3'd0, 3'd0);
        checkAll("noop", 4, 2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        waitEdges(1);
        checkAll("noop.after", 4, 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Change to 3/5, then hold a 6/1 request through DRAIN/SETTLE
        applyStimulus(1'b1, 3'd3, 3'd5);
        waitEdges(1);
        applyStimulus(1'b1, 3'd6, 3'd1);
        checkAll("hold.e0", 4, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        waitEdges(16);
        checkAll("hold.e16", 3, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        waitEdges(8);
        checkAll("hold.e24", 3, 5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        // Held request accepted on the first RUN cycle
        waitEdges(1);
        applyStimulus(1'b0, 3'd0, 3'd0);
        checkAll("hold.e25", 3, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        waitEdges(16);
        checkAll("hold2.e16", 6, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        waitEdges(8);
        checkAll("hold2.e24", 6, 1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        // Change to 2/2 interrupted by reset at E0+10
        waitEdges(1);
        applyStimulus(1'b1, 3'd2, 3'd2);
        waitEdges(1);
        applyStimulus(1'b0, 3'd0, 3'd0);
        checkAll("rstmid.e0", 6, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        waitEdges(9);
        rst = 1'b1;
        waitEdges(1);
        checkAll("rstmid.rst", 1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        waitEdges(62);
        checkAll("rstmid.s62", 1, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        waitEdges(1);
        checkAll("rstmid.s63", 1, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
